// File: rtl/checksum_pkg.sv
// Shared types and ones-complement arithmetic for the incremental checksum updater.
package checksum_pkg;

   localparam int CS_WORD_W = 16;

   typedef logic [CS_WORD_W-1:0] cs_word_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      FOLD  = 2'd2,
      DONE  = 2'd3
   } cs_state_t;

   // 17-bit sum with end-around carry; one fold suffices because the sum never exceeds 0x1FFFE.
   function automatic cs_word_t oc_add(input cs_word_t a, input cs_word_t b);
      logic [CS_WORD_W:0] s;
      s = {1'b0, a} + {1'b0, b};
      return s[CS_WORD_W-1:0] + {{(CS_WORD_W-1){1'b0}}, s[CS_WORD_W]};
   endfunction

endpackage

// File: rtl/checksum_update_multi.sv
// Incremental ones-complement checksum updater (HC' = ~(~HC + sum(~m + m'))) over MAX_WORDS slots,
// fixed latency, optional UDP zero-checksum handling.
module checksum_update_multi
   import checksum_pkg::*;
#(
   parameter int MAX_WORDS = 4,
   parameter bit UDP_MODE  = 1'b0
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      req,
   input  logic [15:0]               old_checksum,
   input  logic [MAX_WORDS-1:0]      word_mask,
   input  logic [16*MAX_WORDS-1:0]   removed_vals,
   input  logic [16*MAX_WORDS-1:0]   new_vals,
   output logic                      busy,
   output logic                      gnt,
   output logic [15:0]               new_checksum
);

   localparam int SLOT_W = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;
   localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(MAX_WORDS - 1);

   cs_state_t                   state_q, state_d;
   logic [SLOT_W-1:0]           slot_q, slot_d;
   cs_word_t                    acc_q, acc_d;
   logic [MAX_WORDS-1:0]        mask_q, mask_d;
   logic [16*MAX_WORDS-1:0]     rem_q, rem_d;
   logic [16*MAX_WORDS-1:0]     nv_q, nv_d;
   logic                        hc_zero_q, hc_zero_d;
   logic                        busy_q, busy_d;
   logic                        gnt_q, gnt_d;
   cs_word_t                    result_q, result_d;
   logic                        accept_s;
   cs_word_t                    m_old_s, m_new_s;

   assign accept_s = req & ~busy_q & (state_q == IDLE);
   assign m_old_s  = rem_q[16*int'(slot_q) +: 16];
   assign m_new_s  = nv_q[16*int'(slot_q) +: 16];

   // State and datapath registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q   <= IDLE;
         slot_q    <= {SLOT_W{1'b0}};
         acc_q     <= 16'h0000;
         mask_q    <= {MAX_WORDS{1'b0}};
         rem_q     <= {(16*MAX_WORDS){1'b0}};
         nv_q      <= {(16*MAX_WORDS){1'b0}};
         hc_zero_q <= 1'b0;
         busy_q    <= 1'b0;
         gnt_q     <= 1'b0;
         result_q  <= 16'h0000;
      end else begin
         state_q   <= state_d;
         slot_q    <= slot_d;
         acc_q     <= acc_d;
         mask_q    <= mask_d;
         rem_q     <= rem_d;
         nv_q      <= nv_d;
         hc_zero_q <= hc_zero_d;
         busy_q    <= busy_d;
         gnt_q     <= gnt_d;
         result_q  <= result_d;
      end
   end

   // Next-state logic: ACCUM walks every slot regardless of mask so latency is fixed.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept_s) state_d = ACCUM; else state_d = IDLE;
         ACCUM:   if (slot_q == LAST_SLOT) state_d = FOLD; else state_d = ACCUM;
         FOLD:    state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Datapath and registered outputs; gnt rises on the edge leaving DONE, busy drops one edge later.
   always_comb begin
      slot_d    = slot_q;
      acc_d     = acc_q;
      mask_d    = mask_q;
      rem_d     = rem_q;
      nv_d      = nv_q;
      hc_zero_d = hc_zero_q;
      gnt_d     = 1'b0;
      result_d  = result_q;
      if (gnt_q) busy_d = 1'b0; else busy_d = busy_q;
      case (state_q)
         IDLE: begin
            if (accept_s) begin
               acc_d     = ~old_checksum;
               slot_d    = {SLOT_W{1'b0}};
               mask_d    = word_mask;
               rem_d     = removed_vals;
               nv_d      = new_vals;
               hc_zero_d = (old_checksum == 16'h0000);
               busy_d    = 1'b1;
            end else begin
               acc_d = acc_q;
            end
         end
         ACCUM: begin
            if (mask_q[slot_q]) acc_d = oc_add(oc_add(acc_q, ~m_old_s), m_new_s);
            else acc_d = acc_q;
            if (slot_q == LAST_SLOT) slot_d = {SLOT_W{1'b0}};
            else slot_d = slot_q + {{(SLOT_W-1){1'b0}}, 1'b1};
         end
         FOLD: acc_d = ~acc_q;
         DONE: begin
            gnt_d = 1'b1;
            if (UDP_MODE && hc_zero_q) result_d = 16'h0000;
            else if (UDP_MODE && (acc_q == 16'h0000)) result_d = 16'hFFFF;
            else result_d = acc_q;
         end
         default: acc_d = acc_q;
      endcase
   end

   assign busy         = busy_q;
   assign gnt          = gnt_q;
   assign new_checksum = result_q;

endmodule

// File: tb/tb_checksum_update_multi.sv
// Scoreboard bench: two instances (plain and UDP mode) share randomized stimulus against a
// plain-arithmetic reference; a posedge+1 monitor checks values, latency and hold behaviour.
module tb_checksum_update_multi;

   localparam int LAT = 6;

   logic        clk = 1'b0;
   logic        reset;
   logic        req;
   logic [15:0] hc;
   logic [3:0]  mask;
   logic [63:0] rem, nw;
   logic        busy0, gnt0, busy1, gnt1;
   logic [15:0] cs0, cs1;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   typedef struct {
      logic [15:0] e0;
      logic [15:0] e1;
      bit          eq0;
      bit          eq1;
      int          acc;
   } sb_item_t;

   sb_item_t sbq[$];
   logic [15:0] last0 = 16'h0000;
   logic [15:0] last1 = 16'h0000;

   checksum_update_multi #(.MAX_WORDS(4), .UDP_MODE(1'b0)) u_dut0 (
      .clk(clk), .reset(reset), .req(req), .old_checksum(hc), .word_mask(mask),
      .removed_vals(rem), .new_vals(nw), .busy(busy0), .gnt(gnt0), .new_checksum(cs0));

   checksum_update_multi #(.MAX_WORDS(4), .UDP_MODE(1'b1)) u_dut1 (
      .clk(clk), .reset(reset), .req(req), .old_checksum(hc), .word_mask(mask),
      .removed_vals(rem), .new_vals(nw), .busy(busy1), .gnt(gnt1), .new_checksum(cs1));

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input bit ok, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (!ok) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic bit cs_match(input logic [15:0] exp, input logic [15:0] act, input bit eq);
      bit zero_e, zero_a;
      zero_e = (exp == 16'h0000) || (exp == 16'hFFFF);
      zero_a = (act == 16'h0000) || (act == 16'hFFFF);
      return (act == exp) || (eq && zero_e && zero_a);
   endfunction

   // Reference: ones-complement sum of ~HC and every active (~m + m'), folded, then complemented.
   function automatic logic [15:0] ref_update(input logic [15:0] h, input logic [3:0] m,
                                              input logic [63:0] r, input logic [63:0] n, input bit udp);
      int unsigned s;
      logic [15:0] w, res;
      w = ~h;
      s = w;
      for (int k = 0; k < 4; k++) begin
         if (m[k]) begin
            w = ~r[16*k +: 16];
            s = s + w + n[16*k +: 16];
            while (s > 32'hFFFF) s = (s & 32'hFFFF) + (s >> 16);
         end
      end
      w = s[15:0];
      res = ~w;
      if (udp) begin
         if (h == 16'h0000) res = 16'h0000;
         else if (res == 16'h0000) res = 16'hFFFF;
      end
      return res;
   endfunction

   function automatic logic [15:0] hdr_sum(input logic [15:0] h [10]);
      int unsigned s = 0;
      for (int k = 0; k < 10; k++) if (k != 5) s = s + h[k];
      while (s > 32'hFFFF) s = (s & 32'hFFFF) + (s >> 16);
      return s[15:0];
   endfunction

   // Monitor: pops on gnt, otherwise checks the result is held; reset forces all outputs to zero.
   always @(posedge clk) begin
      sb_item_t it;
      #1;
      if (!reset) begin
         check("reset_dut0", {busy0, gnt0, cs0} == 18'h0, {14'h0, busy0, gnt0, cs0}, 32'h0);
         check("reset_dut1", {busy1, gnt1, cs1} == 18'h0, {14'h0, busy1, gnt1, cs1}, 32'h0);
         last0 = 16'h0000;
         last1 = 16'h0000;
      end else if (gnt0 || gnt1) begin
         if (sbq.size() == 0) begin
            check("spurious_gnt", 1'b0, {30'h0, gnt1, gnt0}, 32'h0);
         end else begin
            it = sbq.pop_front();
            check("gnt_pair", gnt0 && gnt1, {30'h0, gnt1, gnt0}, 32'h3);
            check("latency", (cyc - it.acc) == LAT, cyc - it.acc, LAT);
            check("result_dut0", cs_match(it.e0, cs0, it.eq0), {16'h0, cs0}, {16'h0, it.e0});
            check("result_dut1", cs_match(it.e1, cs1, it.eq1), {16'h0, cs1}, {16'h0, it.e1});
         end
         last0 = cs0;
         last1 = cs1;
      end else begin
         check("hold_dut0", cs0 == last0, {16'h0, cs0}, {16'h0, last0});
         check("hold_dut1", cs1 == last1, {16'h0, cs1}, {16'h0, last1});
      end
   end

   task automatic issue(input logic [15:0] h, input logic [3:0] m, input logic [63:0] r,
                        input logic [63:0] n, input logic [15:0] e0, input logic [15:0] e1,
                        input bit eq0, input bit eq1, input bit push, input bit poke);
      sb_item_t it;
      int budget;
      budget = 0;
      @(negedge clk);
      while (busy0 || busy1) begin
         if (budget > 40) begin
            check("busy_timeout", 1'b0, {30'h0, busy1, busy0}, 32'h0);
            return;
         end
         budget++;
         @(negedge clk);
      end
      hc = h; mask = m; rem = r; nw = n; req = 1'b1;
      @(posedge clk);
      #1;
      if (push) begin
         it.e0 = e0; it.e1 = e1; it.eq0 = eq0; it.eq1 = eq1; it.acc = cyc;
         sbq.push_back(it);
      end
      @(negedge clk);
      req  = 1'b0;
      hc   = 16'($urandom);
      mask = 4'($urandom);
      rem  = {$urandom, $urandom};
      nw   = {$urandom, $urandom};
      if (poke) begin
         @(negedge clk);
         req = 1'b1;
         @(negedge clk);
         @(negedge clk);
         req = 1'b0;
      end
   endtask

   task automatic issue_model(input logic [15:0] h, input logic [3:0] m, input logic [63:0] r,
                              input logic [63:0] n, input bit poke);
      issue(h, m, r, n, ref_update(h, m, r, n, 1'b0), ref_update(h, m, r, n, 1'b1),
            1'b0, 1'b0, 1'b1, poke);
   endtask

   initial begin
      logic [15:0] h, e, e1;
      logic [3:0]  m;
      logic [63:0] r, n;
      logic [15:0] hdr [10];
      int p, q, budget;

      reset = 1'b0; req = 1'b1;
      hc = 16'h1234; mask = 4'hF; rem = {$urandom, $urandom}; nw = {$urandom, $urandom};
      repeat (2) @(negedge clk);
      reset = 1'b1; req = 1'b0;

      issue(16'hDD2F, 4'b0001, 64'h0000_0000_0000_5555, 64'h0000_0000_0000_3285,
            16'h0000, 16'hFFFF, 1'b0, 1'b0, 1'b1, 1'b0);

      r = {$urandom, $urandom};
      issue(16'hFFFF, 4'b1111, r, r, 16'h0000, 16'hFFFF, 1'b0, 1'b0, 1'b1, 1'b0);

      r = {$urandom, $urandom}; n = {$urandom, $urandom};
      issue(16'h0000, 4'b1111, r, n, ref_update(16'h0000, 4'b1111, r, n, 1'b0), 16'h0000,
            1'b0, 1'b0, 1'b1, 1'b0);

      for (int i = 0; i < 1500; i++) begin
         h = 16'($urandom_range(0, 16'hFFFE));
         m = 4'($urandom);
         r = {$urandom, $urandom};
         issue(h, m, r, r, h, h, 1'b0, 1'b0, 1'b1, 1'b0);
      end

      for (int i = 0; i < 300; i++)
         issue_model(16'($urandom), 4'($urandom), {$urandom, $urandom}, {$urandom, $urandom}, 1'b0);

      for (int i = 0; i < 200; i++) begin
         for (int k = 0; k < 10; k++) hdr[k] = 16'($urandom);
         h = ~hdr_sum(hdr);
         hdr[5] = h;
         p = $urandom_range(0, 9); if (p == 5) p = 4;
         q = $urandom_range(0, 9); if (q == 5 || q == p) q = (p + 1) % 10;
         if (q == 5) q = 6;
         r = {$urandom, $urandom};
         n = {$urandom, $urandom};
         r[15:0] = hdr[p]; r[31:16] = hdr[q];
         hdr[p] = n[15:0]; hdr[q] = n[31:16];
         e = ~hdr_sum(hdr);
         e1 = (h == 16'h0000) ? 16'h0000 : ((e == 16'h0000) ? 16'hFFFF : e);
         issue(h, 4'b0011, r, n, e, e1, 1'b1, 1'b0, 1'b1, 1'b0);
      end

      for (int i = 0; i < 5; i++)
         issue_model(16'($urandom), 4'($urandom), {$urandom, $urandom}, {$urandom, $urandom}, 1'b1);

      issue(16'($urandom), 4'b1111, {$urandom, $urandom}, {$urandom, $urandom},
            16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      reset = 1'b0;
      sbq.delete();
      @(negedge clk);
      reset = 1'b1;
      repeat (12) @(negedge clk);
      issue_model(16'($urandom), 4'($urandom), {$urandom, $urandom}, {$urandom, $urandom}, 1'b0);
      r = {$urandom, $urandom}; n = {$urandom, $urandom};
      issue(16'h0000, 4'b0110, r, n, ref_update(16'h0000, 4'b0110, r, n, 1'b0), 16'h0000,
            1'b0, 1'b0, 1'b1, 1'b0);

      budget = 0;
      while (sbq.size() != 0 && budget < 50) begin
         @(negedge clk);
         budget++;
      end
      check("drain", sbq.size() == 0, sbq.size(), 32'h0);
      repeat (3) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
